// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the four-stage pipelined adder and its result path.
package adder_pipe_pkg;

  localparam int PIPE_LAT = 4;
  localparam int ADD_W    = 64;

  // One adder result as it travels downstream: carry-out above the sum.
  typedef struct packed {
    logic             carry;
    logic [ADD_W-1:0] sum;
  } add_res_t;

endpackage : adder_pipe_pkg

// File: rtl/adder_buf_mem.sv
// Result storage: DEPTH x (DATA_WIDTH+1) register array, one write port,
// asynchronous read port so the FIFO head falls through without a cycle of delay.
module adder_buf_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH:0]      rdata
);

  logic [DATA_WIDTH:0] mem [DEPTH];

  // Write port; the array is cleared on reset so the head reads all-zero
  // before the first result arrives.
  // NOTE: resetting a storage array is normally avoided (it costs a reset net
  // per bit), but here the visible head must be zero after reset and the
  // array is only a few entries deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : adder_buf_mem

// File: rtl/adder_result_buffer.sv
// Captures adder results into a first-word-fall-through FIFO, drains them over
// valid/ready, and returns an issue credit covering results still in the adder.
module adder_result_buffer #(
  parameter int DATA_WIDTH = adder_pipe_pkg::ADD_W,
  parameter int DEPTH      = 8,
  parameter int PIPE_LAT   = adder_pipe_pkg::PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue,
  output logic                   issue_ok,
  input  logic                   in_en,
  input  logic [DATA_WIDTH-1:0]  in_sum,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH:0]    out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   perr,
  input  logic                   err_clr
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INFL_W = $clog2(PIPE_LAT + 1);
  localparam int SUM_W  = CNT_W + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [INFL_W-1:0] infl;
  logic [CNT_W-1:0]  count_nxt;
  logic [INFL_W-1:0] infl_nxt;
  logic              full, pop, push, ovf_set, perr_set;
  logic [SUM_W-1:0]  credit_used;

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = in_en & (~full | pop);
  assign ovf_set   = in_en & full & ~pop;
  assign perr_set  = in_en & ~issue & (infl == '0);

  // Credit is taken from registered state only, so it never loops through
  // the source's issue decision.
  assign credit_used = SUM_W'(count) + SUM_W'(infl);
  assign issue_ok    = (credit_used < SUM_W'(DEPTH));

  adder_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_carry, in_sum}),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  // Next occupancy and in-flight count from this cycle's push/pop/issue/return.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    infl_nxt  = infl;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
    if (issue && !in_en && infl != INFL_W'(PIPE_LAT)) infl_nxt = infl + INFL_W'(1);
    else if (in_en && !issue && infl != '0)           infl_nxt = infl - INFL_W'(1);
  end

  // Pointer, counter and sticky-flag registers.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      infl   <= '0;
      ovf    <= 1'b0;
      perr   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      infl  <= infl_nxt;
      // Clear wins over a same-cycle set.
      ovf   <= err_clr ? 1'b0 : (ovf  | ovf_set);
      perr  <= err_clr ? 1'b0 : (perr | perr_set);
    end
  end

endmodule : adder_result_buffer
